// File: rtl/i2s_transmitter.sv
// I2S playback transmitter: buffers one stereo PCM pair and shifts it out
// MSB-first in standard I2S framing with a divided-down bit clock.
module i2s_transmitter #(
    parameter int DATA_SIZE = 24,
    parameter int SLOT_BITS = 32,
    parameter int CLK_DIV   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic [DATA_SIZE-1:0] left_data,
    input  logic [DATA_SIZE-1:0] right_data,
    output logic                 i2s_clk,
    output logic                 i2s_ws,
    output logic                 i2s_sd,
    output logic                 frame_start,
    output logic                 underrun,
    output logic [7:0]           underrun_count
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int DW         = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;
    logic   run;

    logic [DW-1:0]        div_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_nxt;
    int                   bit_idx;

    logic                 buf_full;
    logic [DATA_SIZE-1:0] buf_left;
    logic [DATA_SIZE-1:0] buf_right;
    logic [DATA_SIZE-1:0] left_shift;
    logic [DATA_SIZE-1:0] right_shift;
    logic [DATA_SIZE-1:0] left_nxt;
    logic [DATA_SIZE-1:0] right_nxt;

    logic shift_evt;
    logic load_evt;
    logic accept;
    logic ws_nxt;
    logic sd_nxt;

    function automatic logic bit_from_msb(input logic [DATA_SIZE-1:0] d, input int pos);
        logic [DATA_SIZE-1:0] t;
        t = d << pos;
        return t[DATA_SIZE-1];
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = RUN;
            RUN:     if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Dropping enable in RUN clears the bus on the very next edge.
    always_comb begin
        run = (state == RUN) && enable;
    end

    // ---------------- bit timing ----------------
    assign shift_evt = run && (div_cnt == DIV_LAST) && i2s_clk;
    assign bit_nxt   = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
    assign load_evt  = shift_evt && (bit_nxt == '0);
    assign accept    = sample_valid && !buf_full;

    // Bit 0 of a frame must already carry the freshly loaded pair.
    assign left_nxt  = load_evt ? (buf_full ? buf_left  : '0) : left_shift;
    assign right_nxt = load_evt ? (buf_full ? buf_right : '0) : right_shift;

    always_comb begin
        bit_idx = 32'(bit_nxt);
        ws_nxt  = (bit_idx >= SLOT_BITS - 1) && (bit_idx <= FRAME_BITS - 2);
        sd_nxt  = 1'b0;
        if (bit_idx < SLOT_BITS) begin
            if (bit_idx < DATA_SIZE) sd_nxt = bit_from_msb(left_nxt, bit_idx);
        end else if (bit_idx - SLOT_BITS < DATA_SIZE) begin
            sd_nxt = bit_from_msb(right_nxt, bit_idx - SLOT_BITS);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            i2s_clk     <= 1'b0;
            bit_cnt     <= LAST_BIT;
            i2s_ws      <= 1'b0;
            i2s_sd      <= 1'b0;
            left_shift  <= '0;
            right_shift <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else if (!run) begin
            div_cnt     <= '0;
            i2s_clk     <= 1'b0;
            bit_cnt     <= LAST_BIT;
            i2s_ws      <= 1'b0;
            i2s_sd      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load_evt;
            underrun    <= load_evt && !buf_full;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                i2s_clk <= ~i2s_clk;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            if (shift_evt) begin
                bit_cnt     <= bit_nxt;
                i2s_ws      <= ws_nxt;
                i2s_sd      <= sd_nxt;
                left_shift  <= left_nxt;
                right_shift <= right_nxt;
            end
        end
    end

    // ---------------- holding buffer ----------------
    // A pair arriving in an underrun load cycle is kept for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full  <= 1'b0;
            buf_left  <= '0;
            buf_right <= '0;
        end else if (load_evt && buf_full) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full  <= 1'b1;
            buf_left  <= left_data;
            buf_right <= right_data;
        end
    end

    assign sample_ready = !buf_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_count <= '0;
        end else if (load_evt && !buf_full && (underrun_count != 8'hFF)) begin
            underrun_count <= underrun_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: a scoreboard of accepted pairs is
// checked frame by frame against the serial stream.
module tb_i2s_transmitter;

    localparam int DATA_SIZE = 24;
    localparam int SLOT_BITS = 32;
    localparam int CLK_DIV   = 2;
    localparam logic [63:0] EXP_WS = 64'h0000_0001_FFFF_FFFE;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic                 sample_valid;
    logic                 sample_ready;
    logic [DATA_SIZE-1:0] left_data;
    logic [DATA_SIZE-1:0] right_data;
    logic                 i2s_clk;
    logic                 i2s_ws;
    logic                 i2s_sd;
    logic                 frame_start;
    logic                 underrun;
    logic [7:0]           underrun_count;

    int checks = 0;
    int errors = 0;

    logic [47:0] sb[$];
    int          pend_at_edge = 0;
    int          ucnt_model   = 0;
    int          frames_done  = 0;
    int          ur_seen      = 0;
    int          mon_b        = 0;
    logic        mon_act      = 1'b0;
    logic        prev_sck     = 1'b0;
    logic [47:0] cur;
    logic [63:0] got_sd, got_ws, exp_sd;
    logic [63:0] last_sd = '0;
    logic [63:0] last_ws = '0;
    logic        exp_ur;

    i2s_transmitter #(
        .DATA_SIZE(DATA_SIZE),
        .SLOT_BITS(SLOT_BITS),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .left_data     (left_data),
        .right_data    (right_data),
        .i2s_clk       (i2s_clk),
        .i2s_ws        (i2s_ws),
        .i2s_sd        (i2s_sd),
        .frame_start   (frame_start),
        .underrun      (underrun),
        .underrun_count(underrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push: pairs accepted on this edge, plus buffer depth before it.
    always @(posedge clk) begin
        pend_at_edge = sb.size();
        if (rst_n && sample_valid && sample_ready) sb.push_back({left_data, right_data});
    end

    // Frame monitor: collects 64 bits per frame and compares against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            ucnt_model = 0;
            mon_act    = 1'b0;
            prev_sck   = 1'b0;
        end else begin
            if (!enable) begin
                mon_act = 1'b0;
            end else if (frame_start) begin
                exp_ur = (pend_at_edge == 0);
                chk("frame_underrun", 64'(underrun), 64'(exp_ur));
                if (underrun) ur_seen++;
                if (exp_ur) begin
                    cur = '0;
                    if (ucnt_model != 255) ucnt_model++;
                end else begin
                    cur = sb.pop_front();
                end
                chk("underrun_count", 64'(underrun_count), 64'(ucnt_model));
                mon_act    = 1'b1;
                mon_b      = 0;
                got_sd     = '0;
                got_ws     = '0;
                got_sd[63] = i2s_sd;
                got_ws[63] = i2s_ws;
            end else if (mon_act && prev_sck && !i2s_clk) begin
                mon_b++;
                got_sd[63-mon_b] = i2s_sd;
                got_ws[63-mon_b] = i2s_ws;
                if (mon_b == 63) begin
                    exp_sd = {cur[47:24], 8'h00, cur[23:0], 8'h00};
                    chk("frame_sd", got_sd, exp_sd);
                    chk("frame_ws", got_ws, EXP_WS);
                    last_sd = got_sd;
                    last_ws = got_ws;
                    mon_act = 1'b0;
                    frames_done++;
                end
            end
            prev_sck = i2s_clk;
        end
    end

    task automatic wait_frames(input int n, input string tag);
        int target;
        int budget;
        target = frames_done + n;
        budget = n * 300;
        while (frames_done < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, 64'(frames_done >= target), 64'd1);
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 400);
        chk(tag, 64'(frame_start), 64'd1);
    endtask

    initial begin
        int n;
        int ur_before;
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        left_data    = '0;
        right_data   = '0;
        repeat (3) @(negedge clk);
        chk("rst_sck",   64'(i2s_clk), 64'd0);
        chk("rst_ws",    64'(i2s_ws), 64'd0);
        chk("rst_sd",    64'(i2s_sd), 64'd0);
        chk("rst_ready", 64'(sample_ready), 64'd1);
        chk("rst_fs",    64'(frame_start), 64'd0);
        chk("rst_ur",    64'(underrun), 64'd0);
        chk("rst_count", 64'(underrun_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: free-running with no samples, divider timing
        enable = 1'b1;
        @(negedge clk); chk("t1_sck_e0", 64'(i2s_clk), 64'd0);
        @(negedge clk); chk("t1_sck_e1", 64'(i2s_clk), 64'd0);
        @(negedge clk); chk("t1_sck_e2", 64'(i2s_clk), 64'd1);
        @(negedge clk); chk("t1_sck_e3", 64'(i2s_clk), 64'd1);
        @(negedge clk); chk("t1_sck_e4", 64'(i2s_clk), 64'd0);
        chk("t1_fs", 64'(frame_start), 64'd1);
        chk("t1_ur", 64'(underrun), 64'd1);
        wait_frames(1, "t1_frame_done");
        chk("t1_count", 64'(underrun_count), 64'd1);

        // 2: preloaded pair, bit layout and WS
        enable = 1'b0;
        repeat (3) @(negedge clk);
        left_data    = 24'hA5C3F0;
        right_data   = 24'h0F1E2D;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("t2_ready_low", 64'(sample_ready), 64'd0);
        enable = 1'b1;
        wait_frames(1, "t2_frame_done");
        chk("t2_sd", last_sd, 64'hA5C3F000_0F1E2D00);
        chk("t2_ws", last_ws, EXP_WS);

        // 3: valid held high with incrementing left values
        ur_before    = ur_seen;
        right_data   = 24'h123456;
        sample_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            left_data = 24'(k);
            n = 0;
            while (!sample_ready && n < 600) begin
                @(negedge clk);
                n++;
            end
            chk("t3_ready_seen", 64'(sample_ready), 64'd1);
            @(negedge clk);
            chk("t3_ready_low", 64'(sample_ready), 64'd0);
        end
        sample_valid = 1'b0;
        wait_frames(2, "t3_frames_done");
        chk("t3_last_left", 64'(last_sd[63:40]), 64'd5);
        chk("t3_no_underrun", 64'(ur_seen - ur_before), 64'd0);

        // 4: disable mid-frame keeps the buffered pair
        left_data    = 24'h111111;
        right_data   = 24'h222222;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        wait_fs("t4_fs");
        left_data    = 24'h333333;
        right_data   = 24'h444444;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("t4_buf_full", 64'(sample_ready), 64'd0);
        repeat (159) @(negedge clk);
        chk("t4_ws_b40", 64'(i2s_ws), 64'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("t4_sck_off", 64'(i2s_clk), 64'd0);
        chk("t4_ws_off",  64'(i2s_ws), 64'd0);
        chk("t4_sd_off",  64'(i2s_sd), 64'd0);
        chk("t4_kept",    64'(sample_ready), 64'd0);
        repeat (10) @(negedge clk);
        enable = 1'b1;
        wait_frames(1, "t4_frame_done");
        chk("t4_sd", last_sd, 64'h333333_00_444444_00);

        // 5: saturating underrun counter
        wait_frames(300, "t5_frames_done");
        chk("t5_count_sat", 64'(underrun_count), 64'd255);

        // 6: async reset mid-frame with buffer full
        wait_fs("t6_fs");
        left_data    = 24'h7E7E7E;
        right_data   = 24'h818181;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("t6_buf_full", 64'(sample_ready), 64'd0);
        repeat (20) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_sck",   64'(i2s_clk), 64'd0);
        chk("t6_ws",    64'(i2s_ws), 64'd0);
        chk("t6_sd",    64'(i2s_sd), 64'd0);
        chk("t6_ready", 64'(sample_ready), 64'd1);
        chk("t6_fs",    64'(frame_start), 64'd0);
        chk("t6_ur",    64'(underrun), 64'd0);
        chk("t6_count", 64'(underrun_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_frames(1, "t6_frame_done");
        chk("t6_first_underrun", 64'(underrun_count), 64'd1);
        chk("t6_sd_zero", last_sd, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
